// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed display scanner.
// Holds the scan FSM state type and the all-off anode pattern.
package display_pkg;

    typedef enum logic {
        S_BLANK,
        S_SHOW
    } scan_state_t;

    // Widest anode bus any board top uses; callers slice to their width.
    localparam int MAX_DIGITS = 16;
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot counter: counts 0..PRESCALE-1 while en is high.
// Ports: clk, rst_n, en (run), count (slot position), slot_end (last cycle).
module scan_prescaler #(
    parameter int PRESCALE = 50000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    output logic [$clog2(PRESCALE)-1:0] count,
    output logic                        slot_end
);
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    assign slot_end = en && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= slot_end ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller feeding one shared seven_seg decoder.
// Ports: load_valid/load_ready/load_data/load_mask (word handshake into a
// shadow buffer), dec_in/dec_en (decoder), digit_an_n (active-low anodes),
// frame_start (pulse on digit 0 slot start).
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [4*DIGITS-1:0] load_data,
    input  logic [DIGITS-1:0]   load_mask,
    output logic [3:0]          dec_in,
    output logic                dec_en,
    output logic [DIGITS-1:0]   digit_an_n,
    output logic                frame_start
);
    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF = ANODE_OFF[DIGITS-1:0];

    scan_state_t state, state_nx;

    // run is low only on the cycle between reset release and the first
    // edge; it holds the scan at slot 0 so that edge can launch the
    // registered frame_start for digit 0.
    logic          run;
    logic [CW-1:0] count;
    logic          slot_end;
    logic [IW-1:0] idx, idx_nx;

    logic [4*DIGITS-1:0] act_data, pend_data, data_nx;
    logic [DIGITS-1:0]   act_mask, pend_mask, mask_nx;
    logic                pend_full, pend_full_nx;
    logic                accept, commit;

    logic [DIGITS-1:0] an_d;
    logic              en_d, fs_d;
    logic [3:0]        din_d;

    scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_pre (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (run),
        .count    (count),
        .slot_end (slot_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BLANK;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        unique case (state)
            S_BLANK: if (run && count == BLANK_LAST) state_nx = S_SHOW;
            S_SHOW:  if (slot_end) state_nx = S_BLANK;
        endcase
        if (slot_end) begin
            idx_nx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // Outputs are launched from the next-cycle scan position so they line
    // up with the counter value they describe.
    always_comb begin
        accept       = load_valid && load_ready;
        commit       = run && pend_full && count == '0 && idx == '0;
        data_nx      = commit ? pend_data : act_data;
        mask_nx      = commit ? pend_mask : act_mask;
        pend_full_nx = accept || (pend_full && !commit);
        an_d         = AN_OFF;
        en_d         = 1'b0;
        din_d        = 4'h0;
        if (state_nx == S_SHOW) begin
            din_d = data_nx[{idx_nx, 2'b00} +: 4];
            if (!mask_nx[idx_nx]) begin
                an_d[idx_nx] = 1'b0;
                en_d         = 1'b1;
            end
        end
        fs_d = (!run || slot_end) && idx_nx == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            act_data    <= '0;
            act_mask    <= '0;
            pend_data   <= '0;
            pend_mask   <= '0;
            pend_full   <= 1'b0;
            load_ready  <= 1'b1;
            digit_an_n  <= AN_OFF;
            dec_en      <= 1'b0;
            dec_in      <= 4'h0;
            frame_start <= 1'b0;
        end else begin
            run        <= 1'b1;
            act_data   <= data_nx;
            act_mask   <= mask_nx;
            pend_full  <= pend_full_nx;
            load_ready <= !pend_full_nx;
            if (accept) begin
                pend_data <= load_data;
                pend_mask <= load_mask;
            end
            digit_an_n  <= an_d;
            dec_en      <= en_d;
            dec_in      <= din_d;
            frame_start <= fs_d;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with a frame-level reference model.
// Stimulus pushes per-cycle expectations; a monitor pops and compares.
module tb_display_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 10;
    localparam int BLANK    = 2;
    localparam int FRAME    = DIGITS * PRESCALE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = '0;
    logic [3:0]  load_mask = '0;
    logic [3:0]  dec_in;
    logic        dec_en;
    logic [3:0]  digit_an_n;
    logic        frame_start;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_mask   (load_mask),
        .dec_in      (dec_in),
        .dec_en      (dec_en),
        .digit_an_n  (digit_an_n),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic [3:0] an;
        logic       en;
        logic [3:0] din;
        logic       dchk;
        logic       rdy;
        logic       fs;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   t = -1;
    bit   done = 0;

    // Reference state: what the display shows this frame and what waits.
    logic [15:0] m_act_d, m_pend_d;
    logic [3:0]  m_act_m, m_pend_m;
    logic        m_full;

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h at %0t", n, got, want, $time);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e = '{an: 4'hF, en: 1'b0, din: 4'h0, dchk: 1'b1, rdy: 1'b1,
              fs: 1'b0};
        return e;
    endfunction

    task automatic model_clear();
        m_act_d = '0; m_act_m = '0;
        m_pend_d = '0; m_pend_m = '0;
        m_full = 1'b0;
    endtask

    task automatic rst_cycle(input bit rel);
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        load_valid = 1'b0;
        sb.push_back(reset_exp());
        if (rel) t = 0;
    endtask

    task automatic cycle(input logic v, input logic [15:0] d,
                         input logic [3:0] m);
        exp_t e;
        int   slot, dg;
        logic rdy;
        @(negedge clk);
        slot = t % PRESCALE;
        dg   = (t / PRESCALE) % DIGITS;
        rdy  = !m_full;
        e = '{an: 4'hF, en: 1'b0, din: 4'h0, dchk: 1'b0, rdy: rdy,
              fs: (t % FRAME == 0)};
        if (slot >= BLANK && !m_act_m[dg]) begin
            e.an   = 4'hF & ~(4'(1) << dg);
            e.en   = 1'b1;
            e.din  = 4'((m_act_d >> (4 * dg)) & 16'hF);
            e.dchk = 1'b1;
        end
        sb.push_back(e);
        if (t % FRAME == 0 && m_full) begin
            m_act_d = m_pend_d;
            m_act_m = m_pend_m;
            m_full  = 1'b0;
        end
        load_valid = v;
        load_data  = d;
        load_mask  = m;
        if (v && rdy) begin
            m_pend_d = d;
            m_pend_m = m;
            m_full   = 1'b1;
        end
        t++;
    endtask

    task automatic idle();
        cycle(1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic async_reset();
        #3 rst_n = 1'b0;
        load_valid = 1'b0;
        #1;
        chk("async_rst_an", 32'(digit_an_n), 32'hF);
        chk("async_rst_en", 32'(dec_en), 32'd0);
        chk("async_rst_din", 32'(dec_in), 32'd0);
        chk("async_rst_rdy", 32'(load_ready), 32'd1);
        chk("async_rst_fs", 32'(frame_start), 32'd0);
        model_clear();
        t = -1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (done) break;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
                continue;
            end
            e = sb.pop_front();
            chk("anodes", 32'(digit_an_n), 32'(e.an));
            chk("dec_en", 32'(dec_en), 32'(e.en));
            if (e.dchk) chk("dec_in", 32'(dec_in), 32'(e.din));
            chk("load_ready", 32'(load_ready), 32'(e.rdy));
            chk("frame_start", 32'(frame_start), 32'(e.fs));
            chk("one_anode", 32'($countones(~digit_an_n) <= 1), 32'd1);
        end
    end

    initial begin : stim
        model_clear();
        repeat (3) rst_cycle(1'b0);
        rst_cycle(1'b1);
        repeat (45) idle();

        while (t % FRAME != 22) idle();
        cycle(1'b1, 16'h4A7C, 4'b0000);
        repeat (100) idle();

        while (t % FRAME != 5) idle();
        cycle(1'b1, 16'h9E51, 4'b0100);
        repeat (90) idle();

        repeat (130) cycle(1'b1, 16'($urandom), 4'($urandom_range(0, 1)));

        repeat (400)
            cycle($urandom_range(0, 15) == 0, 16'($urandom), 4'($urandom));

        while (!(m_full == 1'b0 && t % FRAME == 12)) idle();
        cycle(1'b1, 16'($urandom), 4'h0);
        cycle(1'b0, 16'h0, 4'h0);
        async_reset();
        repeat (2) rst_cycle(1'b0);
        rst_cycle(1'b1);
        repeat (45) idle();

        #2;
        done = 1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
